// File: rtl/general_sma_trig_gen.sv
// Rising-edge-triggered pulse-train generator that drives an SMA trigger output.
// Pulse width, period and count are captured at the start of each train.
module general_sma_trig_gen #(
  parameter logic OUT_POL = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        Start,
  input  logic        Stop,
  input  logic [7:0]  Cfg_Width,
  input  logic [15:0] Cfg_Period,
  input  logic [15:0] Cfg_Count,
  output logic        Out_Trig_SMA,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Pulse_Cnt
);

  // state | meaning
  // IDLE  | no train running; waiting for a qualified Start edge
  // HIGH  | output active; r_timer counts down the remaining width
  // LOW   | output idle between pulses; r_timer counts down the gap
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_start_d1, r_armed, r_stop_req, w_stop_req_nxt;
  logic [7:0]  r_width, w_width_nxt;
  logic [15:0] r_period, w_period_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic        r_trig, w_trig_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic [15:0] r_pulse_cnt, w_pulse_cnt_nxt;
  logic        w_start_edge;

  function automatic logic [7:0] eff_width(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

  // Gap length Pe - W, where Pe = max(P, W+1) guarantees at least one idle cycle.
  function automatic logic [15:0] low_len(input logic [7:0] w, input logic [15:0] p);
    logic [15:0] we;
    logic [15:0] pe;
    we = {8'd0, eff_width(w)};
    pe = (p > we) ? p : (we + 16'd1);
    return pe - we;
  endfunction

  // r_armed keeps a Start held high through reset from counting as an edge.
  assign w_start_edge = Start & ~r_start_d1 & r_armed;

  always_comb begin
    w_state_nxt     = r_state;
    w_stop_req_nxt  = r_stop_req;
    w_width_nxt     = r_width;
    w_period_nxt    = r_period;
    w_count_nxt     = r_count;
    w_timer_nxt     = r_timer;
    w_trig_nxt      = r_trig;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_pulse_cnt_nxt = r_pulse_cnt;
    case (r_state)
      IDLE: begin
        w_trig_nxt = ~OUT_POL;
        w_busy_nxt = 1'b0;
        if (w_start_edge && !Stop && !r_done) begin
          w_width_nxt     = Cfg_Width;
          w_period_nxt    = Cfg_Period;
          w_count_nxt     = Cfg_Count;
          w_timer_nxt     = {8'd0, eff_width(Cfg_Width)} - 16'd1;
          w_stop_req_nxt  = 1'b0;
          w_trig_nxt      = OUT_POL;
          w_busy_nxt      = 1'b1;
          w_pulse_cnt_nxt = 16'd1;
          w_state_nxt     = HIGH;
        end
      end
      HIGH: begin
        if (Stop) w_stop_req_nxt = 1'b1;
        if (r_timer == 16'd0) begin
          w_trig_nxt = ~OUT_POL;
          if (r_stop_req || Stop) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_timer_nxt = low_len(r_width, r_period) - 16'd1;
            w_state_nxt = LOW;
          end
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      LOW: begin
        if (Stop) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_timer == 16'd0) begin
          if (r_count == 16'd0 || r_pulse_cnt < r_count) begin
            w_trig_nxt      = OUT_POL;
            w_pulse_cnt_nxt = r_pulse_cnt + 16'd1;
            w_timer_nxt     = {8'd0, eff_width(r_width)} - 16'd1;
            w_state_nxt     = HIGH;
          end else begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: begin
        w_trig_nxt  = ~OUT_POL;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state     <= IDLE;
      r_start_d1  <= 1'b0;
      r_armed     <= 1'b0;
      r_stop_req  <= 1'b0;
      r_width     <= 8'd0;
      r_period    <= 16'd0;
      r_count     <= 16'd0;
      r_timer     <= 16'd0;
      r_trig      <= ~OUT_POL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d1  <= Start;
      r_armed     <= r_armed | ~Start;
      r_stop_req  <= w_stop_req_nxt;
      r_width     <= w_width_nxt;
      r_period    <= w_period_nxt;
      r_count     <= w_count_nxt;
      r_timer     <= w_timer_nxt;
      r_trig      <= w_trig_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
    end
  end

  assign Out_Trig_SMA = r_trig;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign Pulse_Cnt    = r_pulse_cnt;

endmodule
